seq_multiplier: RTL and testbench

Parametrised multi-cycle shift-add multiplier for the ALU datapath. It replaces the fixed 32-bit unsigned multiply unit. It owns its own iteration counter and start/busy/done handshake, so the controller no longer sequences each step. It supports signed and unsigned operands and returns the full double-width product as one HI/LO word.

---
 rtl/seq_multiplier.sv | 106 ++++++++++
 tb/tb_seq_multiplier.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier, signed or unsigned operands.
// Full 2*WIDTH-bit product delivered with a one-cycle done pulse.
module seq_multiplier #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] dataOut
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] dout_q, dout_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  // -2^(WIDTH-1) negates to itself, which reads correctly as unsigned
  assign mag_a = (is_signed && dataA[WIDTH-1]) ? -dataA : dataA;
  assign mag_b = (is_signed && dataB[WIDTH-1]) ? -dataB : dataB;

  assign sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
  assign prod = {hi_q, lo_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          neg_d   = is_signed &
                    (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
          mcand_d = mag_a;
          hi_d    = '0;
          lo_d    = mag_b;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        hi_d  = sum[WIDTH:1];
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = S_SIGN;
      end
      S_SIGN: begin
        dout_d  = neg_q ? -prod : prod;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign dataOut = dout_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: 32-bit and 8-bit instances.
// Checks products, latency, busy length, handshake and reset abort.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        st32, sg32;
  logic [31:0] a32, b32;
  logic        busy32, done32;
  logic [63:0] out32;
  logic        st8, sg8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] out8;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(st32),
    .is_signed(sg32), .dataA(a32), .dataB(b32),
    .busy(busy32), .done(done32), .dataOut(out32)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(st8),
    .is_signed(sg8), .dataA(a8), .dataB(b8),
    .busy(busy8), .done(done8), .dataOut(out8)
  );

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total_cnt++;
    if (got !== exp)
      $display("FAIL %s got %h want %h", nm, got, exp);
    else
      pass_cnt++;
  endtask

  task automatic run32(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic s,
                       output logic [63:0] res,
                       output int lat,
                       output int bc);
    @(negedge clk);
    st32 = 1'b1; a32 = a; b32 = b; sg32 = s;
    @(posedge clk); #1;
    st32 = 1'b0; a32 = '0; b32 = '0; sg32 = 1'b0;
    lat = 0; bc = 0;
    while (!done32 && lat < 100) begin
      if (busy32) bc++;
      @(posedge clk); #1;
      lat++;
    end
    res = out32;
  endtask

  task automatic run8(input logic [7:0] a,
                      input logic [7:0] b,
                      input logic s,
                      output logic [15:0] res,
                      output int lat);
    @(negedge clk);
    st8 = 1'b1; a8 = a; b8 = b; sg8 = s;
    @(posedge clk); #1;
    st8 = 1'b0; a8 = '0; b8 = '0; sg8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out8;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    st32 = 0; sg32 = 0; a32 = 0; b32 = 0;
    st8 = 0; sg8 = 0; a8 = 0; b8 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_done32", 64'(done32), 64'd0);
    chk("rst_out32", out32, 64'd0);
    chk("rst_out8", 64'(out8), 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_unsigned_max;
    logic [63:0] r;
    int lat, bc;
    run32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, lat, bc);
    chk("umax_prod", r, 64'hFFFFFFFE00000001);
    chk("umax_lat", 64'(lat), 64'd33);
    chk("umax_busy", 64'(bc), 64'd33);
    @(posedge clk); #1;
    chk("umax_done_1cyc", 64'(done32), 64'd0);
  endtask

  task automatic test_signed;
    logic [63:0] r;
    int lat, bc;
    run32(-32'sd3, 32'd5, 1'b1, r, lat, bc);
    chk("s_m3x5", r, 64'hFFFFFFFFFFFFFFF1);
    run32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, r, lat, bc);
    chk("s_m1xm1", r, 64'h1);
    run32(32'h80000000, 32'h80000000, 1'b1, r, lat, bc);
    chk("s_minxmin", r, 64'h4000000000000000);
    chk("s_lat", 64'(lat), 64'd33);
  endtask

  task automatic test_mode;
    logic [63:0] r;
    int lat, bc;
    run32(32'h80000000, 32'd2, 1'b0, r, lat, bc);
    chk("mode_u", r, 64'h0000000100000000);
    run32(32'h80000000, 32'd2, 1'b1, r, lat, bc);
    chk("mode_s", r, 64'hFFFFFFFF00000000);
  endtask

  task automatic test_width8;
    logic [15:0] r;
    int lat;
    run8(8'h80, 8'd127, 1'b1, r, lat);
    chk("w8_signed", 64'(r), 64'hC080);
    chk("w8_lat", 64'(lat), 64'd9);
    run8(8'd200, 8'd255, 1'b0, r, lat);
    chk("w8_unsigned", 64'(r), 64'hC738);
  endtask

  task automatic test_handshake;
    int lat, nd;
    @(negedge clk);
    st32 = 1'b1; a32 = 32'd7; b32 = 32'd6; sg32 = 1'b0;
    @(posedge clk); #1;
    st32 = 1'b0; a32 = '0; b32 = '0;
    lat = 0; nd = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    st32 = 1'b1; a32 = 32'd9; b32 = 32'd9;
    @(negedge clk);
    st32 = 1'b0; a32 = '0; b32 = '0;
    while (!done32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hs_busy_ignore", out32, 64'h2A);
    // done cycle: issue next operation straight away
    st32 = 1'b1; a32 = 32'd9; b32 = 32'd9;
    @(posedge clk); #1;
    st32 = 1'b0; a32 = '0; b32 = '0;
    chk("hs_single_done", 64'(done32), 64'd0);
    lat = 0;
    while (!done32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_prod", out32, 64'h51);
    chk("b2b_lat", 64'(lat), 64'd33);
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) nd++;
    end
    chk("hs_no_extra_done", 64'(nd), 64'd0);
  endtask

  task automatic test_reset_mid;
    logic [63:0] r;
    int lat, bc, nd;
    @(negedge clk);
    st32 = 1'b1; a32 = 32'hFFFFFFFF; b32 = 32'hFFFFFFFF;
    sg32 = 1'b0;
    @(posedge clk); #1;
    st32 = 1'b0; a32 = '0; b32 = '0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_busy", 64'(busy32), 64'd0);
    chk("mid_done", 64'(done32), 64'd0);
    chk("mid_out", out32, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) nd++;
    end
    chk("mid_no_done", 64'(nd), 64'd0);
    run32(32'd3, 32'd4, 1'b0, r, lat, bc);
    chk("mid_after", r, 64'd12);
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_mode();
    test_width8();
    test_handshake();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
